// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: default parameter values and
// the forwarding-select encoding used by the execute-stage bypass muxes.
package hazard_pkg;

    localparam int unsigned DEF_REG_ADDR_WIDTH    = 5;
    localparam int unsigned DEF_MDU_LATENCY       = 4;
    localparam int unsigned DEF_STALL_COUNT_WIDTH = 16;
    localparam int unsigned FWD_SEL_WIDTH         = 2;

    // Execute-stage operand source select
    typedef enum logic [FWD_SEL_WIDTH-1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks the single in-flight multiply/divide op: busy flag, cycles-remaining
// down-counter and the destination register it will write.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start_i           an MDU op leaves execute this cycle
//   start_dest_i      destination of the starting op
//   busy_o            an op is in flight
//   pending_dest_o    destination latched at the last accepted start
//   writeback_o       one-cycle pulse in the op's final busy cycle
//   overlap_error_o   sticky: a start arrived while an op was still running
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int unsigned MDU_LATENCY    = DEF_MDU_LATENCY
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic [REG_ADDR_WIDTH-1:0] start_dest_i,
    output logic                      busy_o,
    output logic [REG_ADDR_WIDTH-1:0] pending_dest_o,
    output logic                      writeback_o,
    output logic                      overlap_error_o
);

    localparam int unsigned CNT_WIDTH = $clog2(MDU_LATENCY + 1);

    logic                      busy_q, busy_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                      err_q, err_d;
    logic                      last_c;

    // Final busy cycle: result is written back now, a new start is legal
    assign last_c = busy_q && (cnt_q == CNT_WIDTH'(1));

    // Next-state: count down while busy; accept a start only when idle or finishing
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        dest_d = dest_q;
        err_d  = err_q;
        if (busy_q) begin
            if (last_c) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end
        if (start_i) begin
            if (!busy_q || last_c) begin
                busy_d = 1'b1;
                cnt_d  = CNT_WIDTH'(MDU_LATENCY);
                dest_d = start_dest_i;
            end else begin
                // Overlapping start is dropped; the running op is untouched
                err_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            dest_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            dest_q <= dest_d;
            err_q  <= err_d;
        end
    end

    assign busy_o          = busy_q;
    assign pending_dest_o  = dest_q;
    assign writeback_o     = last_c;
    assign overlap_error_o = err_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: operand forwarding selects, load-use / branch / MDU
// stall generation, MDU occupancy tracking and a saturating stall counter.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   branch_decode, branch_not_equal_decode, jump_pc_decode   control-transfer flags
//   rs/rt_decode, rs/rt_execute        source register addresses
//   write_reg_*, reg_write_*           destination and write enable per stage
//   mem_to_reg_execute/memory          bit 0 marks a load
//   mdu_start_execute, mdu_write_reg_execute, mdu_op_decode   MDU interface
//   clear_stats                        clears stall_cycle_count
//   stall_fetch, stall_decode, flush_execute                 combined stall
//   forward_a/b_decode, forward_a/b_execute                  bypass selects
//   mdu_busy, mdu_writeback, mdu_overlap_error               MDU status
//   stall_cycle_count                  saturating stalled-cycle count
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH    = DEF_REG_ADDR_WIDTH,
    parameter int unsigned MDU_LATENCY       = DEF_MDU_LATENCY,
    parameter int unsigned STALL_COUNT_WIDTH = DEF_STALL_COUNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         branch_decode,
    input  logic                         branch_not_equal_decode,
    input  logic                         jump_pc_decode,
    input  logic [REG_ADDR_WIDTH-1:0]    rs_decode,
    input  logic [REG_ADDR_WIDTH-1:0]    rt_decode,
    input  logic [REG_ADDR_WIDTH-1:0]    rs_execute,
    input  logic [REG_ADDR_WIDTH-1:0]    rt_execute,
    input  logic [REG_ADDR_WIDTH-1:0]    write_reg_execute,
    input  logic [REG_ADDR_WIDTH-1:0]    write_reg_memory,
    input  logic [REG_ADDR_WIDTH-1:0]    write_reg_writeback,
    input  logic                         reg_write_execute,
    input  logic                         reg_write_memory,
    input  logic                         reg_write_writeback,
    input  logic [1:0]                   mem_to_reg_execute,
    input  logic [1:0]                   mem_to_reg_memory,
    input  logic                         mdu_start_execute,
    input  logic [REG_ADDR_WIDTH-1:0]    mdu_write_reg_execute,
    input  logic                         mdu_op_decode,
    input  logic                         clear_stats,
    output logic                         stall_fetch,
    output logic                         stall_decode,
    output logic                         flush_execute,
    output logic                         forward_a_decode,
    output logic                         forward_b_decode,
    output logic [FWD_SEL_WIDTH-1:0]     forward_a_execute,
    output logic [FWD_SEL_WIDTH-1:0]     forward_b_execute,
    output logic                         mdu_busy,
    output logic                         mdu_writeback,
    output logic                         mdu_overlap_error,
    output logic [STALL_COUNT_WIDTH-1:0] stall_cycle_count
);

    logic [REG_ADDR_WIDTH-1:0]    mdu_pending_dest;
    logic                         load_stall_c;
    logic                         branch_stall_c;
    logic                         mdu_stall_c;
    logic                         ctrl_xfer_c;
    logic                         stall_c;
    logic [STALL_COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                         unused_mem_to_reg_hi;

    // Only bit 0 of the mem_to_reg selects matters here
    assign unused_mem_to_reg_hi = mem_to_reg_execute[1] ^ mem_to_reg_memory[1];

    // Register 0 never carries a dependency
    function automatic logic nz_match(input logic [REG_ADDR_WIDTH-1:0] src,
                                      input logic [REG_ADDR_WIDTH-1:0] dst,
                                      input logic                      en);
        return en && (src != '0) && (src == dst);
    endfunction

    // Memory stage is the younger producer, so it wins over writeback
    function automatic fwd_sel_e ex_fwd(input logic [REG_ADDR_WIDTH-1:0] src);
        if (nz_match(src, write_reg_memory, reg_write_memory)) begin
            return FWD_MEM;
        end else if (nz_match(src, write_reg_writeback, reg_write_writeback)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

    mdu_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .MDU_LATENCY    (MDU_LATENCY)
    ) u_mdu (
        .clk             (clk),
        .reset_n         (reset_n),
        .start_i         (mdu_start_execute),
        .start_dest_i    (mdu_write_reg_execute),
        .busy_o          (mdu_busy),
        .pending_dest_o  (mdu_pending_dest),
        .writeback_o     (mdu_writeback),
        .overlap_error_o (mdu_overlap_error)
    );

    // Forwarding selects
    assign forward_a_decode  = nz_match(rs_decode, write_reg_memory, reg_write_memory);
    assign forward_b_decode  = nz_match(rt_decode, write_reg_memory, reg_write_memory);
    assign forward_a_execute = ex_fwd(rs_execute);
    assign forward_b_execute = ex_fwd(rt_execute);

    // Stall sources
    assign ctrl_xfer_c = branch_decode | branch_not_equal_decode | jump_pc_decode;

    assign load_stall_c = nz_match(rt_execute, rs_decode, mem_to_reg_execute[0])
                        | nz_match(rt_execute, rt_decode, mem_to_reg_execute[0]);

    // Branches resolve in decode, so they need results not yet forwardable
    assign branch_stall_c = ctrl_xfer_c &
        (nz_match(rs_decode, write_reg_execute, reg_write_execute)
       | nz_match(rt_decode, write_reg_execute, reg_write_execute)
       | nz_match(rs_decode, write_reg_memory, mem_to_reg_memory[0])
       | nz_match(rt_decode, write_reg_memory, mem_to_reg_memory[0]));

    assign mdu_stall_c = (mdu_busy | mdu_start_execute) &
        (mdu_op_decode
       | nz_match(rs_decode, mdu_pending_dest, 1'b1)
       | nz_match(rt_decode, mdu_pending_dest, 1'b1)
       | nz_match(rs_decode, mdu_write_reg_execute, 1'b1)
       | nz_match(rt_decode, mdu_write_reg_execute, 1'b1));

    assign stall_c       = load_stall_c | branch_stall_c | mdu_stall_c;
    assign stall_decode  = stall_c;
    assign stall_fetch   = stall_c;
    assign flush_execute = stall_c;

    // Saturating stall counter; clear wins over increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear_stats) begin
            stall_cnt_d = '0;
        end else if (stall_c && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycle_count = stall_cnt_q;

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5: register-address width; register 0 is hard-wired zero.
REQ-002 SHALL have parameter MDU_LATENCY, default 4, legal range 2..16: busy cycles of the multi-cycle multiply/divide unit (MDU).
REQ-003 SHALL have parameter STALL_COUNT_WIDTH, default 16: stall-statistics counter width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports branch_decode, branch_not_equal_decode, jump_pc_decode, input, 1 each: decode-stage control-transfer flags.
REQ-007 SHALL have ports rs_decode, rt_decode, rs_execute, rt_execute, input, REG_ADDR_WIDTH: source register addresses.
REQ-008 SHALL have ports write_reg_execute, write_reg_memory, write_reg_writeback, input, REG_ADDR_WIDTH: destination per stage.
REQ-009 SHALL have ports reg_write_execute, reg_write_memory, reg_write_writeback, input, 1: write enable per stage.
REQ-010 SHALL have ports mem_to_reg_execute, mem_to_reg_memory, input, 2: bit 0 marks a load.
REQ-011 SHALL have port mdu_start_execute, input, 1: an MDU op leaves execute this cycle.
REQ-012 SHALL have port mdu_write_reg_execute, input, REG_ADDR_WIDTH: the MDU op's destination.
REQ-013 SHALL have port mdu_op_decode, input, 1: the decode instruction is an MDU op or reads MDU results.
REQ-014 SHALL have port clear_stats, input, 1: synchronously clears stall_cycle_count.
REQ-015 SHALL have ports stall_fetch, stall_decode, flush_execute, output, 1 each.
REQ-016 SHALL have ports forward_a_decode, forward_b_decode, output, 1 each; forward_a_execute, forward_b_execute, output, 2 each.
REQ-017 SHALL have ports mdu_busy, mdu_writeback, mdu_overlap_error, output, 1 each; stall_cycle_count, output, STALL_COUNT_WIDTH.

Function
REQ-018 SHALL assert forward_x_decode when the decode source is nonzero, equals write_reg_memory, and reg_write_memory is set.
REQ-019 SHALL set forward_x_execute to 2'b10 for a nonzero source matching a memory-stage write, else 2'b01 for a writeback-stage match, else 2'b00; the memory stage wins a tie.
REQ-020 SHALL raise the load stall when mem_to_reg_execute[0] is set, rt_execute is nonzero, and rt_execute equals rs_decode or rt_decode.
REQ-021 SHALL raise the branch stall when any control-transfer flag is set and a nonzero decode source matches either an execute-stage write or a memory-stage load destination.
REQ-022 SHALL hold MDU state as a busy flag, a down-counter of width $clog2(MDU_LATENCY+1), and a pending destination register.
REQ-023 SHALL, on mdu_start_execute while idle, next cycle assert mdu_busy, load the counter with MDU_LATENCY, and latch the destination.
REQ-024 SHALL decrement the counter each busy cycle, pulse mdu_writeback for exactly one cycle when it equals 1, and deassert mdu_busy the following cycle.
REQ-025 SHALL raise the MDU stall when (mdu_busy or mdu_start_execute) holds and either mdu_op_decode is set or a nonzero decode source equals the pending or starting destination.
REQ-026 SHALL treat mdu_start_execute while busy as illegal: ignore it, leave the op in flight unchanged, and set sticky mdu_overlap_error until reset.
REQ-027 SHALL accept mdu_start_execute in the cycle mdu_writeback pulses as legal; the unit restarts with no idle cycle.
REQ-028 SHALL drive stall_decode as the OR of the load, branch and MDU stalls, and drive stall_fetch and flush_execute equal to stall_decode.
REQ-029 SHALL increment stall_cycle_count each cycle stall_decode is high, saturate at all-ones, and let clear_stats take priority over the increment.

Reset
REQ-030 SHALL, when reset_n is low, immediately clear mdu_busy, the counter, the pending destination, mdu_writeback, mdu_overlap_error and stall_cycle_count.
REQ-031 SHALL have reset abort any in-flight MDU op with no mdu_writeback pulse; the combinational outputs then follow their inputs.

Structure
REQ-032 SHALL place the forwarding encodings (FWD_NONE=00, FWD_WB=01, FWD_MEM=10) and the default parameter values in shared package hazard_pkg.
REQ-033 SHALL implement the MDU busy/counter/pending logic in one sub-module, mdu_scoreboard; forwarding and stall logic stay in the top level.

Verification
REQ-034 SHALL cover: rs_execute=5, write_reg_memory=5, reg_write_memory=1, write_reg_writeback=5, reg_write_writeback=1 -> forward_a_execute=10.
REQ-035 SHALL cover: load with rt_execute=8 and rs_decode=8 -> stall_decode=stall_fetch=flush_execute=1 for one cycle; rt_execute=0 -> no stall.
REQ-036 SHALL cover: MDU_LATENCY=4, start with destination 9 at cycle 0 -> mdu_busy high cycles 1-4, mdu_writeback at cycle 4, decode reading r9 stalled cycles 0-4.
REQ-037 SHALL cover: second mdu_start_execute at cycle 2 -> mdu_overlap_error=1 sticky, original writeback still at cycle 4.
REQ-038 SHALL cover: reset_n low at cycle 2 of an MDU op -> mdu_busy=0 immediately, no mdu_writeback, stall_cycle_count=0.
REQ-039 SHALL cover: STALL_COUNT_WIDTH=4 with 20 stalled cycles -> count=15 held; clear_stats during a stall -> count=0.
